reg_file_nrw: RTL
=================

Name: reg_file_nrw

Overview:
- Parametrised register file: DEPTH entries of WIDTH bits, one synchronous write port with byte-lane strobes, two read ports.
- Generalises the single enable-gated N-bit register to an addressable array.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- Sits between decode and execute as the datapath's architectural register storage.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; any value from 2 up.
- AW, $clog2(DEPTH), address width (derived; do not override).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 0, 1 = a read of the address being written this cycle returns the merged new data combinationally.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- we  in  1  write enable
- waddr  in  AW  write address
- wstrb  in  WIDTH/8  byte-lane write strobes; bit i covers data[8i+7:8i]
- wdata  in  WIDTH  write data
- raddr_a  in  AW  read address, port A
- rdata_a  out  WIDTH  read data, port A
- raddr_b  in  AW  read address, port B
- rdata_b  out  WIDTH  read data, port B
- wr_err  out  1  registered flag: last-cycle write targeted an address >= DEPTH

Behaviour:
- Reset: on a rising clk edge with rst==0, all entries are set to 0 and wr_err is cleared. Reset has priority over any write in the same cycle. Reads remain combinational during reset and return the current contents, which are 0 after the first reset edge.
- Write: on a rising clk edge with rst==1, we==1, waddr<DEPTH, and the target not protected by ZERO_REG:
  - entry[waddr] byte i <= wdata byte i where wstrb[i]==1;
  - bytes with wstrb[i]==0 are unchanged.
  - wstrb==0 with we==1 is a legal no-op.
- Protected entry: with ZERO_REG=1, a write to address 0 is silently dropped and does not set wr_err.
- Out-of-range write: waddr>=DEPTH (possible only when DEPTH is not a power of 2) is dropped; wr_err <= 1 on that edge. Any other non-reset edge sets wr_err <= 0.
- Read: rdata_x = entry[raddr_x], combinational, zero cycles of latency from the address. Out-of-range raddr returns 0. With ZERO_REG=1, raddr==0 returns 0.
- Write-to-read latency with BYPASS=0: a written value is visible on the read ports from the cycle after the write edge. A same-cycle read of the written address returns the old value.
- BYPASS=1: when we==1, rst==1, raddr_x==waddr, and the write is legal, rdata_x = old entry with the strobed bytes replaced by wdata.
  - Bypass never applies to a protected address 0 or an out-of-range address.
  - Bypass is suppressed while rst==0.
- Both read ports may name the same address, including the one being written. Both ports return identical data under the rules above.
- No internal state machine beyond the storage array and wr_err. All state updates occur only on clk rising edges.

Decomposition:
- Shared package reg_pkg holds:
  - the byte-lane merge function merge_bytes(old, new, strb);
  - the constant BYTE=8;
  - the lane-count macro LANES(w)=w/8.
- Natural sub-module: rf_entry, one WIDTH-bit register with a synchronous active-low reset, per-byte write enables, and a protect input. It is instantiated DEPTH times through a generate loop.
- Read muxes and bypass logic stay in the top module.

Test Plan:
- Reset and readback: hold rst=0 for 2 edges after random writes, then read all addresses on both ports -> every rdata = 0 and wr_err = 0.
- Full-word write: write 0xDEADBEEF to address 5 with wstrb=4'hF, read raddr_a=5 on the next cycle -> 0xDEADBEEF. A same-cycle read returns 0 when BYPASS=0 and 0xDEADBEEF when BYPASS=1.
- Byte strobes: write 0x11223344 to address 7 with strb F, then 0xAABBCCDD with strb 4'b0101 -> address 7 reads 0x11BB33DD.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to address 0 -> both ports read 0 and wr_err = 0. With ZERO_REG=0, the same write -> reads 0xFFFFFFFF.
- Out-of-range: with DEPTH=20, write to address 25 -> no entry changes, wr_err = 1 for exactly one cycle, and raddr_b=25 reads 0.
- Reset priority: in the same cycle, assert rst=0 and we=1 with address 3 and data 0x12345678 -> address 3 reads 0 afterwards. With BYPASS=1, rdata during that cycle shows no bypassed data.

Source files
------------

// File: rtl/reg_pkg.sv
// ============================================================================
// Module : reg_pkg
// Shared constants and the byte-lane merge helper for the register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef REG_PKG_LANES_DEFINED
`define REG_PKG_LANES_DEFINED
`define LANES(w) ((w) / 8)
`endif

package reg_pkg;

  localparam int BYTE  = 8;
  // Widest data path the merge helper supports; callers cast to/from it.
  localparam int MAX_W = 1024;
  localparam int MAX_L = MAX_W / BYTE;

  function automatic logic [MAX_W-1:0] merge_bytes(
    input logic [MAX_W-1:0] old_v,
    input logic [MAX_W-1:0] new_v,
    input logic [MAX_L-1:0] strb
  );
    logic [MAX_W-1:0] r;
    r = old_v;
    for (int i = 0; i < MAX_L; i++) begin
      if (strb[i]) r[i*BYTE +: BYTE] = new_v[i*BYTE +: BYTE];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_entry.sv
// ============================================================================
// Module : rf_entry
// One storage word with per-byte write enables and a write-protect input.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_entry
  import reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH/BYTE-1:0]   i_be,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_protect,
  output logic [WIDTH-1:0]        o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (!i_protect && (|i_be)) begin
      r_q <= WIDTH'(merge_bytes(MAX_W'(r_q), MAX_W'(i_wdata), MAX_L'(i_be)));
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_nrw.sv
// ============================================================================
// Module : reg_file_nrw
// DEPTH x WIDTH register file: one byte-strobed write port, two read ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_file_nrw
  import reg_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WIDTH/BYTE-1:0] wstrb,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [AW-1:0]         raddr_a,
  output logic [WIDTH-1:0]      rdata_a,
  input  logic [AW-1:0]         raddr_b,
  output logic [WIDTH-1:0]      rdata_b,
  output logic                  wr_err
);

  localparam int LN = WIDTH / BYTE;

  logic [WIDTH-1:0] w_q [DEPTH];
  logic             w_in_range;
  logic             w_wr_legal;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             r_wr_err;

  assign w_in_range = ({1'b0, waddr} < (AW+1)'(DEPTH));
  assign w_wr_legal = we && rst && w_in_range &&
                      !((ZERO_REG != 0) && (waddr == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [LN-1:0] w_be;
    // Reset priority is handled inside the entry, so no rst gating here.
    assign w_be = (we && (waddr == AW'(i))) ? wstrb : '0;

    rf_entry #(
      .WIDTH(WIDTH)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .i_be     (w_be),
      .i_wdata  (wdata),
      .i_protect((ZERO_REG != 0) && (i == 0)),
      .o_q      (w_q[i])
    );
  end

  always_comb begin
    w_rd_a = '0;
    if (({1'b0, raddr_a} < (AW+1)'(DEPTH)) &&
        !((ZERO_REG != 0) && (raddr_a == '0))) begin
      w_rd_a = w_q[raddr_a];
    end
    if ((BYPASS != 0) && w_wr_legal && (raddr_a == waddr)) begin
      w_rd_a = WIDTH'(merge_bytes(MAX_W'(w_rd_a), MAX_W'(wdata), MAX_L'(wstrb)));
    end
  end

  always_comb begin
    w_rd_b = '0;
    if (({1'b0, raddr_b} < (AW+1)'(DEPTH)) &&
        !((ZERO_REG != 0) && (raddr_b == '0))) begin
      w_rd_b = w_q[raddr_b];
    end
    if ((BYPASS != 0) && w_wr_legal && (raddr_b == waddr)) begin
      w_rd_b = WIDTH'(merge_bytes(MAX_W'(w_rd_b), MAX_W'(wdata), MAX_L'(wstrb)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= we && !w_in_range;
    end
  end

  assign rdata_a = w_rd_a;
  assign rdata_b = w_rd_b;
  assign wr_err  = r_wr_err;

endmodule

`default_nettype wire
